// File: rtl/count_cascade_display.sv
// Extends an upstream single-digit decade counter to three BCD digits and
// drives a multiplexed active-low 7-segment display with a sticky error flag.
module count_cascade_display #(
    parameter int unsigned SCAN_DIV = 4,
    parameter bit          BLANK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic [3:0] number,
    input  logic       zero,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       carry,
    output logic       borrow,
    output logic [6:0] seg,
    output logic [2:0] dig_sel,
    output logic       err
);

    localparam logic [15:0] DIV_TC = 16'(SCAN_DIV - 1);

    logic [3:0]  r_prev, r_units, r_tens, r_hund;
    logic        r_carry, r_borrow, r_err;
    logic [15:0] r_div;
    logic [1:0]  r_idx;
    logic [6:0]  r_seg;
    logic [2:0]  r_dig_sel;

    logic        w_wrap_up, w_wrap_dn, w_bad, w_up_ev, w_dn_ev, w_div_tc;
    logic [3:0]  w_diff, w_digit;
    logic [1:0]  w_idx_nxt;
    logic        w_blank;
    logic [6:0]  w_seg_nxt;

    function automatic logic [6:0] f_enc(input logic [3:0] d);
        case (d)
            4'd0:    f_enc = 7'b1000000;
            4'd1:    f_enc = 7'b1111001;
            4'd2:    f_enc = 7'b0100100;
            4'd3:    f_enc = 7'b0110000;
            4'd4:    f_enc = 7'b0011001;
            4'd5:    f_enc = 7'b0010010;
            4'd6:    f_enc = 7'b0000010;
            4'd7:    f_enc = 7'b1111000;
            4'd8:    f_enc = 7'b0000000;
            4'd9:    f_enc = 7'b0010000;
            default: f_enc = 7'b0111111;
        endcase
    endfunction

    // Any 9<->0 step is a wrap and never a step error; mode only qualifies the event.
    always_comb begin
        w_wrap_up = (r_prev == 4'd9) && (number == 4'd0);
        w_wrap_dn = (r_prev == 4'd0) && (number == 4'd9);
        w_diff    = (number > r_prev) ? (number - r_prev) : (r_prev - number);
        w_bad     = (number > 4'd9) || (zero != (number == 4'd0)) ||
                    (!(w_wrap_up || w_wrap_dn) && (w_diff > 4'd1));
        w_up_ev   = w_wrap_up && zero && mode && !w_bad;
        w_dn_ev   = w_wrap_dn && !mode && !w_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= 4'd0;
            r_units  <= 4'd0;
            r_tens   <= 4'd0;
            r_hund   <= 4'd0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_prev   <= number;
            r_units  <= number;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            if (w_bad)
                r_err <= 1'b1;
            if (w_up_ev) begin
                if (r_tens == 4'd9) begin
                    r_tens <= 4'd0;
                    if (r_hund == 4'd9) begin
                        r_hund  <= 4'd0;
                        r_carry <= 1'b1;
                    end else begin
                        r_hund <= r_hund + 4'd1;
                    end
                end else begin
                    r_tens <= r_tens + 4'd1;
                end
            end else if (w_dn_ev) begin
                if (r_tens == 4'd0) begin
                    r_tens <= 4'd9;
                    if (r_hund == 4'd0) begin
                        r_hund   <= 4'd9;
                        r_borrow <= 1'b1;
                    end else begin
                        r_hund <= r_hund - 4'd1;
                    end
                end else begin
                    r_tens <= r_tens - 4'd1;
                end
            end
        end
    end

    // The display register is loaded from the index it will hold after this edge,
    // so dig_sel and seg switch together.
    always_comb begin
        w_div_tc  = (r_div == DIV_TC);
        w_idx_nxt = r_idx;
        if (w_div_tc)
            w_idx_nxt = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        w_digit = r_units;
        w_blank = 1'b0;
        case (w_idx_nxt)
            2'd1: begin
                w_digit = r_tens;
                w_blank = BLANK_EN && (r_hund == 4'd0) && (r_tens == 4'd0);
            end
            2'd2: begin
                w_digit = r_hund;
                w_blank = BLANK_EN && (r_hund == 4'd0);
            end
            default: ;
        endcase
        w_seg_nxt = w_blank ? 7'b1111111 : f_enc(w_digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= 16'd0;
            r_idx     <= 2'd0;
            r_seg     <= 7'b1000000;
            r_dig_sel <= 3'b110;
        end else begin
            r_div     <= w_div_tc ? 16'd0 : r_div + 16'd1;
            r_idx     <= w_idx_nxt;
            r_seg     <= w_seg_nxt;
            r_dig_sel <= ~(3'b001 << w_idx_nxt);
        end
    end

    assign units    = r_units;
    assign tens     = r_tens;
    assign hundreds = r_hund;
    assign carry    = r_carry;
    assign borrow   = r_borrow;
    assign err      = r_err;
    assign seg      = r_seg;
    assign dig_sel  = r_dig_sel;

endmodule

// File: tb/tb_count_cascade_display.sv
// Bench for count_cascade_display: directed vector tables, hand sequences for
// wrap/scan/reset corners, and random counting checked against a value model.
module tb_count_cascade_display;

    localparam int SD = 4;
    localparam logic [6:0] ENC [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b1;
    logic [3:0] number = 4'd0;
    logic       zero = 1'b1;
    logic [3:0] units, tens, hundreds;
    logic       carry, borrow, err;
    logic [6:0] seg;
    logic [2:0] dig_sel;

    int total = 0;
    int bad = 0;

    count_cascade_display #(.SCAN_DIV(SD), .BLANK_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .number(number), .zero(zero),
        .units(units), .tens(tens), .hundreds(hundreds), .carry(carry),
        .borrow(borrow), .seg(seg), .dig_sel(dig_sel), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: the 3-digit value is held as an integer, the upper two
    // digits as one 0..99 number; scan position derives from cycles since reset.
    int m_prev, m_units, m_high, m_cyc;
    bit m_err, m_carry, m_borrow;
    logic [6:0] m_seg;
    logic [2:0] m_sel;
    int carry_cnt, borrow_cnt;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_units = 0; m_high = 0; m_cyc = 0;
        m_err = 0; m_carry = 0; m_borrow = 0;
        m_seg = 7'b1000000; m_sel = 3'b110;
    endtask

    task automatic model_edge(input bit md, input int num, input bit z);
        int pos, d, diff;
        bit blank, wrap, badc;
        m_cyc++;
        pos = (m_cyc / SD) % 3;
        d = (pos == 0) ? m_units : (pos == 1) ? (m_high % 10) : (m_high / 10);
        blank = (pos == 1 && m_high == 0) || (pos == 2 && m_high < 10);
        m_seg = blank ? 7'b1111111 : (d > 9) ? 7'b0111111 : ENC[d];
        m_sel = 3'b111;
        m_sel[pos] = 1'b0;
        diff = (num > m_prev) ? num - m_prev : m_prev - num;
        wrap = (m_prev == 9 && num == 0) || (m_prev == 0 && num == 9);
        badc = (num > 9) || (z != (num == 0)) || (!wrap && diff > 1);
        m_carry = 0;
        m_borrow = 0;
        if (!badc && m_prev == 9 && num == 0 && z && md) begin
            m_carry = (m_high == 99);
            m_high = (m_high + 1) % 100;
        end else if (!badc && m_prev == 0 && num == 9 && !md) begin
            m_borrow = (m_high == 0);
            m_high = (m_high + 99) % 100;
        end
        m_err = m_err | badc;
        m_prev = num;
        m_units = num;
    endtask

    task automatic tick(input bit md, input int num, input bit z);
        mode = md;
        number = 4'(num);
        zero = z;
        @(posedge clk);
        model_edge(md, num, z);
        #1;
        carry_cnt += int'(carry);
        borrow_cnt += int'(borrow);
        chk("units", units, m_units);
        chk("tens", tens, m_high % 10);
        chk("hundreds", hundreds, m_high / 10);
        chk("carry", carry, m_carry);
        chk("borrow", borrow, m_borrow);
        chk("err", err, m_err);
        chk("seg", seg, m_seg);
        chk("dig_sel", dig_sel, m_sel);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_units"}, units, 0);
        chk({tag, "_tens"}, tens, 0);
        chk({tag, "_hund"}, hundreds, 0);
        chk({tag, "_carry"}, carry, 0);
        chk({tag, "_borrow"}, borrow, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_seg"}, seg, 7'b1000000);
        chk({tag, "_dig_sel"}, dig_sel, 3'b110);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        number = 4'd0;
        zero = 1'b1;
        #1;
        chk_reset_vals(tag);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_vals({tag, "_rel"});
    endtask

    task automatic up_steps(input int n, inout int cur);
        for (int i = 0; i < n; i++) begin
            cur = (cur + 1) % 10;
            tick(1'b1, cur, cur == 0);
        end
    endtask

    typedef struct {
        bit md; int num; bit z;
        int u, t, h; bit c, b, e;
    } vec_t;

    initial begin
        vec_t vt [8];
        int cur;
        bit md;
        int prev_sel, run, order_ok;

        vt[0] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        vt[1] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        vt[2] = '{0, 9, 0, 9, 9, 9, 0, 1, 0};
        vt[3] = '{0, 8, 0, 8, 9, 9, 0, 0, 0};
        vt[4] = '{0, 7, 0, 7, 9, 9, 0, 0, 0};
        vt[5] = '{0, 4, 1, 4, 9, 9, 0, 0, 1};
        vt[6] = '{0, 3, 0, 3, 9, 9, 0, 0, 1};
        vt[7] = '{0, 2, 0, 2, 9, 9, 0, 0, 1};

        carry_cnt = 0;
        borrow_cnt = 0;
        model_reset();
        @(negedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // post-reset down wrap to 999, then a bad digit making err sticky
        do_reset("rst_a");
        for (int i = 0; i < 8; i++) begin
            tick(vt[i].md, vt[i].num, vt[i].z);
            chk($sformatf("vec%0d_u", i), units, vt[i].u);
            chk($sformatf("vec%0d_t", i), tens, vt[i].t);
            chk($sformatf("vec%0d_h", i), hundreds, vt[i].h);
            chk($sformatf("vec%0d_c", i), carry, vt[i].c);
            chk($sformatf("vec%0d_b", i), borrow, vt[i].b);
            chk($sformatf("vec%0d_e", i), err, vt[i].e);
        end
        cur = 2;
        for (int i = 0; i < 15; i++) begin
            cur = (cur + 9) % 10;
            tick(1'b0, cur, cur == 0);
        end
        chk("err_sticky", err, 1);

        // 24 up steps: two tens wraps, no carry
        do_reset("rst_b");
        carry_cnt = 0;
        cur = 0;
        tick(1'b1, 0, 1);
        for (int i = 0; i < 24; i++) begin
            cur = (cur + 1) % 10;
            tick(1'b1, cur, cur == 0);
            if (i == 9) chk("t1_first_wrap_tens", tens, 1);
        end
        chk("t1_tens", tens, 2);
        chk("t1_units", units, 4);
        chk("t1_hund", hundreds, 0);
        chk("t1_no_carry", carry_cnt, 0);

        // count up to 999 then wrap once to 000
        do_reset("rst_c");
        cur = 0;
        up_steps(999, cur);
        chk("t2_999_h", hundreds, 9);
        chk("t2_999_t", tens, 9);
        chk("t2_999_u", units, 9);
        carry_cnt = 0;
        up_steps(1, cur);
        chk("t2_carry", carry, 1);
        chk("t2_zero_h", hundreds, 0);
        chk("t2_zero_t", tens, 0);
        chk("t2_zero_u", units, 0);
        up_steps(3, cur);
        chk("t2_carry_once", carry_cnt, 1);

        // random legal walks with direction changes, one episode gets an error
        for (int ep = 0; ep < 4; ep++) begin
            do_reset($sformatf("rst_r%0d", ep));
            cur = 0;
            md = 1'b1;
            for (int s = 0; s < 200; s++) begin
                int r, num;
                bit z;
                r = int'($urandom_range(0, 99));
                num = cur;
                if (r < 10) md = ~md;
                else if (r < 20) num = cur;
                else if (r < 23) num = (cur == 9 && !md) ? 0 : (cur == 0 && md) ? 9 : cur;
                else num = md ? (cur + 1) % 10 : (cur + 9) % 10;
                z = (num == 0);
                if (ep == 3 && s == 150) begin
                    tick(md, int'($urandom_range(10, 15)), 1'b0);
                end else begin
                    cur = num;
                    tick(md, num, z);
                end
            end
        end

        // scan of value 007 with leading-zero blanking
        do_reset("rst_d");
        cur = 0;
        up_steps(7, cur);
        repeat (2) tick(1'b1, 7, 1'b0);
        prev_sel = dig_sel;
        run = 0;
        order_ok = 1;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 7, 1'b0);
            if (dig_sel != 3'(prev_sel)) begin
                if (!((prev_sel == 3'b110 && dig_sel == 3'b101) ||
                      (prev_sel == 3'b101 && dig_sel == 3'b011) ||
                      (prev_sel == 3'b011 && dig_sel == 3'b110))) order_ok = 0;
                if (run != 0) chk("t5_run_len", run, SD);
                run = 1;
                prev_sel = dig_sel;
            end else begin
                if (run != 0) run++;
            end
            if (dig_sel == 3'b110) chk("t5_seg_units", seg, 7'b1111000);
            else if (dig_sel == 3'b101) chk("t5_seg_tens", seg, 7'b1111111);
            else chk("t5_seg_hund", seg, 7'b1111111);
        end
        chk("t5_order", order_ok, 1);

        // value 123 then reset mid-scan
        do_reset("rst_e");
        cur = 0;
        up_steps(123, cur);
        chk("t6_h", hundreds, 1);
        chk("t6_t", tens, 2);
        chk("t6_u", units, 3);
        repeat (5) tick(1'b1, 3, 1'b0);
        do_reset("t6_mid");
        tick(1'b1, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
